// File: rtl/tff_count_sequencer_pkg.sv
// Shared definitions for the T-FF count sequencer: FSM state encoding and
// count-direction constants.
package tff_count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_count_sequencer_tff_bit.sv
// Single toggle flip-flop cell; the sequencer's bank is built from these.
module tff_bit (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Sequencer that turns a bank of T flip-flops into a loadable up/down counter
// with a programmable terminal value and a start/busy/done handshake.
module tff_count_sequencer
  import tff_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] init_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec
);

  state_t           state;
  state_t           next_state;
  logic             dir_q;
  logic [WIDTH-1:0] init_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] up_vec;
  logic [WIDTH-1:0] dn_vec;

  // Run parameters are captured only when a start is accepted in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dir_q   <= DIR_DOWN;
      init_q  <= '0;
      limit_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        dir_q   <= dir;
        init_q  <= init_val;
        limit_q <= limit;
      end
    end
  end

  // A bit toggles when every lower bit is about to carry (up) or borrow (down).
  assign up_vec[0] = 1'b1;
  assign dn_vec[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign up_vec[i] = &count[i-1:0];
    assign dn_vec[i] = &(~count[i-1:0]);
  end

  always_comb begin
    next_state = state;
    t_vec      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          next_state = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (stop) begin
          next_state = IDLE;
        end else begin
          t_vec      = count ^ init_q;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Stop outranks a limit match so an aborted run never pulses done.
        if (stop)
          next_state = IDLE;
        else if (count == limit_q)
          next_state = DONE;
        else
          t_vec = (dir_q == DIR_UP) ? up_vec : dn_vec;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    tff_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .t     (t_vec[b]),
      .q     (count[b])
    );
  end

endmodule

// File: doc/tff_count_sequencer.md
# tff_count_sequencer

Sequencer that drives the toggle inputs of a bank of WIDTH T flip-flops so the bank acts as a loadable up/down counter with a programmable terminal value. A start/busy/done handshake lets a host launch a count run. The sequencer computes the per-bit toggle vector every cycle. The flip-flop bank holds all counter state. Used wherever the bootcamp designs need a self-timed count built from T-FF cells.

## Interface
- WIDTH, 4, counter and toggle-bank width (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a run; sampled only in IDLE
- dir  in  1  1 = count up, 0 = count down; captured with start
- init_val  in  WIDTH  value loaded into the bank at run start; captured with start
- limit  in  WIDTH  terminal value; captured with start
- stop  in  1  abort the current run; effective in LOAD/RUN
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in DONE
- count  out  WIDTH  current bank value, driven directly from the T-FF outputs
- t_vec  out  WIDTH  toggle vector applied to the bank this cycle (debug visibility)

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: t_vec=0. If start=1, capture dir, init_val and limit into dir_q, init_q and limit_q, then go to LOAD.
- LOAD: t_vec = count ^ init_q, so the bank equals init_q after one edge. Then go to RUN.
- RUN, count == limit_q: t_vec=0. Go to DONE.
- RUN, otherwise, counting up: t_vec[0]=1; t_vec[i] = AND of count[i-1:0].
- RUN, otherwise, counting down: t_vec[0]=1; t_vec[i] = AND of ~count[i-1:0].
- DONE: t_vec=0, done=1. Go to IDLE next edge.
- stop=1 in LOAD or RUN: t_vec=0, go to IDLE, count holds. Stop has priority over a limit match in the same cycle; no done pulse is produced.
- Counting wraps modulo 2^WIDTH: up from all-ones goes to 0, down from 0 goes to all-ones.
- Run length = (limit_q − init_q) mod 2^WIDTH steps when counting up, (init_q − limit_q) mod 2^WIDTH when counting down.
- start in LOAD, RUN or DONE is ignored and not queued. dir, init_val and limit are don't-care outside the start sample.
- Reset (asynchronous, any state): state=IDLE, count=0, captured registers=0, busy=0, done=0, t_vec=0.

## Timing
- E0 is the edge that samples start=1 in IDLE. After E0: state=LOAD, busy=1.
- After E1: count=init_q, state=RUN.
- Each subsequent edge advances count by one step while count ≠ limit_q.
- With N steps, done is high in the cycle following edge E(N+2), and busy falls at that same edge.
- The edge after done, state=IDLE. A new start can be sampled there, giving a minimum of N+4 cycles start-to-start.
- init_q == limit_q: N=0, so done is high after E2.
- stop sampled high at edge Ek takes effect at Ek: busy=0 after Ek and count holds its pre-Ek value.
- Reset asserted mid-run clears all outputs immediately, without waiting for a clock.
- t_vec is combinational from state, count and captured registers. count is registered (bank outputs); the bank toggles on the same edge the state register updates.

## Structure
- Shared package (or localparam include): state encoding for IDLE/LOAD/RUN/DONE; DIR_UP=1 and DIR_DOWN=0 constants.
- One sub-module, tff_bit: a single T flip-flop with clk, reset (async active-low, clears to 0), t and q. Instantiate WIDTH copies in a generate loop.
- The top level contains the FSM, the capture registers and the t_vec logic.

## Test plan
- Reset held low, then released → count=0, busy=0, done=0, t_vec=0 with no clock edges required.
- WIDTH=4, up, init=2, limit=5, start pulse → count steps 2,3,4,5; done high exactly one cycle after E5; busy falls at E5.
- Down with wrap, init=1, limit=14 → count steps 1,0,15,14; done after E5.
- init=limit=9, up → no counting steps after LOAD; done high after E2; count stays 9.
- Up, init=0, limit=10, stop at count=4 → busy drops, count holds 4, no done. A start pulse during that run is ignored with no change to count.
- Reset asserted during RUN at count=6 → count=0 and state IDLE asynchronously. A following start with init=3, limit=4 completes normally, with done after E3.
